// File: rtl/dmem_axi_lite_master.sv
// AXI4-Lite master for the DCache uncached/MMIO path: one 32-bit access per start pulse, no bursts.
// Ack arrives 3 cycles after start with a zero-wait slave; stalls follow AXI ready/valid, and any start while busy is ignored.
module dmem_axi_lite_master #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_burst_private,
    input  logic                burst_type_private,
    input  logic [31:0]         address_write_private,
    input  logic [31:0]         address_read_private,
    input  logic [31:0]         data_write_private,
    output logic                mem_ack_private,
    output logic [31:0]         data_read_input_private,
    output logic                resp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [3:0]          m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [DATA_W-1:0]   wdata_q, wdata_nxt;
    logic [3:0]          wstrb_q, wstrb_nxt;
    logic                awvalid_q, awvalid_nxt;
    logic                wvalid_q, wvalid_nxt;
    logic                bready_q, bready_nxt;
    logic                arvalid_q, arvalid_nxt;
    logic                rready_q, rready_nxt;
    logic                aw_done_q, aw_done_nxt;
    logic                w_done_q, w_done_nxt;
    logic                ack_q, ack_nxt;
    logic                err_q, err_nxt;
    logic [31:0]         rdata_q, rdata_nxt;
    logic                busy_q, busy_nxt;

    logic aw_hs, w_hs, aw_seen, w_seen;
    logic unused_resp_lsb;

    assign aw_hs   = awvalid_q & m_axi_awready;
    assign w_hs    = wvalid_q & m_axi_wready;
    assign aw_seen = aw_done_q | aw_hs;
    assign w_seen  = w_done_q | w_hs;

    // Only bit 1 distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        wdata_nxt   = wdata_q;
        wstrb_nxt   = wstrb_q;
        awvalid_nxt = awvalid_q;
        wvalid_nxt  = wvalid_q;
        bready_nxt  = bready_q;
        arvalid_nxt = arvalid_q;
        rready_nxt  = rready_q;
        aw_done_nxt = aw_done_q;
        w_done_nxt  = w_done_q;
        ack_nxt     = 1'b0;
        err_nxt     = err_q;
        rdata_nxt   = rdata_q;

        case (state)
            IDLE: begin
                if (start_burst_private) begin
                    if (burst_type_private) begin
                        addr_nxt    = ADDR_W'(address_write_private);
                        wdata_nxt   = DATA_W'(data_write_private);
                        wstrb_nxt   = 4'hF;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                        state_nxt   = WR_REQ;
                    end else begin
                        addr_nxt    = ADDR_W'(address_read_private);
                        arvalid_nxt = 1'b1;
                        state_nxt   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each valid drops right after its own handshake.
                awvalid_nxt = awvalid_q & ~m_axi_awready;
                wvalid_nxt  = wvalid_q & ~m_axi_wready;
                if (aw_seen && w_seen) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    bready_nxt  = 1'b1;
                    state_nxt   = WR_RESP;
                end else begin
                    aw_done_nxt = aw_seen;
                    w_done_nxt  = w_seen;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_nxt = 1'b0;
                    err_nxt    = m_axi_bresp[1];
                    ack_nxt    = 1'b1;
                    state_nxt  = DONE;
                end
            end
            RD_REQ: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_nxt = 1'b0;
                    rdata_nxt  = 32'(m_axi_rdata);
                    err_nxt    = m_axi_rresp[1];
                    ack_nxt    = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            wstrb_q   <= wstrb_nxt;
            awvalid_q <= awvalid_nxt;
            wvalid_q  <= wvalid_nxt;
            bready_q  <= bready_nxt;
            arvalid_q <= arvalid_nxt;
            rready_q  <= rready_nxt;
            aw_done_q <= aw_done_nxt;
            w_done_q  <= w_done_nxt;
            ack_q     <= ack_nxt;
            err_q     <= err_nxt;
            rdata_q   <= rdata_nxt;
            busy_q    <= busy_nxt;
        end
    end

    assign mem_ack_private         = ack_q;
    assign data_read_input_private = rdata_q;
    assign resp_err                = err_q;
    assign busy                    = busy_q;
    assign m_axi_awaddr            = addr_q;
    assign m_axi_awprot            = PROT;
    assign m_axi_awvalid           = awvalid_q;
    assign m_axi_wdata             = wdata_q;
    assign m_axi_wstrb             = wstrb_q;
    assign m_axi_wvalid            = wvalid_q;
    assign m_axi_bready            = bready_q;
    assign m_axi_araddr            = addr_q;
    assign m_axi_arprot            = PROT;
    assign m_axi_arvalid           = arvalid_q;
    assign m_axi_rready            = rready_q;

endmodule

// File: tb/tb_dmem_axi_lite_master.sv
// Directed bench for dmem_axi_lite_master: configurable-delay AXI4-Lite slave plus a result scoreboard.
module tb_dmem_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_burst_private = 1'b0;
    logic        burst_type_private = 1'b0;
    logic [31:0] address_write_private = '0;
    logic [31:0] address_read_private = '0;
    logic [31:0] data_write_private = '0;
    logic        mem_ack_private;
    logic [31:0] data_read_input_private;
    logic        resp_err;
    logic        busy;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    always #5 clk = ~clk;

    dmem_axi_lite_master #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .start_burst_private(start_burst_private), .burst_type_private(burst_type_private),
        .address_write_private(address_write_private), .address_read_private(address_read_private),
        .data_write_private(data_write_private), .mem_ack_private(mem_ack_private),
        .data_read_input_private(data_read_input_private), .resp_err(resp_err), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Slave configuration and bookkeeping
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0;
    logic        cfg_b_stall = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        pend_b = 1'b0, pend_r = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
    int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0, ack_n = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_b = 1'b0; pend_r = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
        end else begin
            if (mem_ack_private) ack_n++;
            if (m_axi_bvalid && m_axi_bready) begin pend_b = 1'b0; b_hs_n++; end
            if (m_axi_rvalid && m_axi_rready) begin pend_r = 1'b0; r_hs_n++; end
            if (m_axi_awvalid && m_axi_awready) begin aw_seen = 1'b1; aw_hs_n++; cap_awaddr = m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin
                w_seen = 1'b1; w_hs_n++; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
            end
            if (aw_seen && w_seen) begin pend_b = 1'b1; aw_seen = 1'b0; w_seen = 1'b0; end
            if (m_axi_arvalid && m_axi_arready) begin pend_r = 1'b1; ar_hs_n++; cap_araddr = m_axi_araddr; end
        end
    end

    always @(negedge clk) begin
        if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
        else begin m_axi_awready = 1'b0; aw_cnt = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= cfg_w_dly); w_cnt++; end
        else begin m_axi_wready = 1'b0; w_cnt = 0; end
        if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
        else begin m_axi_arready = 1'b0; ar_cnt = 0; end
        m_axi_bvalid = pend_b && !cfg_b_stall;
        m_axi_bresp  = cfg_bresp;
        m_axi_rvalid = pend_r;
        m_axi_rdata  = cfg_rdata;
        m_axi_rresp  = cfg_rresp;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, waits (bounded) for ack, checks it against the scoreboard head.
    // restart[n] re-drives start in the n-th cycle after the accepted one.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [7:0] restart, input string tag,
                          output int arv_cyc, output logic [1:0] vsnap);
        int   n;
        logic got;
        exp_t e;
        n = 0; got = 1'b0; arv_cyc = 0; vsnap = 2'b00;
        burst_type_private    = wr;
        address_write_private = addr;
        address_read_private  = addr;
        data_write_private    = wd;
        start_burst_private   = 1'b1;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            start_burst_private = (n < 8) ? restart[n[2:0]] : 1'b0;
            if (m_axi_arvalid) arv_cyc++;
            if (n == 2) vsnap = {m_axi_awvalid, m_axi_wvalid};
            if (mem_ack_private) got = 1'b1;
        end
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        check({tag, "_rdata"}, data_read_input_private, e.data);
        check({tag, "_resp_err"}, 32'(resp_err), 32'(e.err));
        check({tag, "_busy_in_ack"}, 32'(busy), 32'd1);
        @(negedge clk);
        start_burst_private = 1'b0;
        check({tag, "_ack_one_cycle"}, 32'(mem_ack_private), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_rdata_held"}, data_read_input_private, e.data);
    endtask

    initial begin
        logic [31:0] last_rd;
        int          ac, ar0, b0;
        logic [1:0]  vs;
        last_rd = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                 m_axi_rready, mem_ack_private, busy, resp_err}), 32'd0);
        check("reset_rdata", data_read_input_private, 32'd0);
        check("reset_prot", 32'({m_axi_awprot, m_axi_arprot}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: zero-wait write
        sb.push_back({last_rd, 1'b0});
        do_req(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3, 8'h00, "wr1", ac, vs);
        check("wr1_awaddr", cap_awaddr, 32'h1000_0004);
        check("wr1_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("wr1_wstrb", 32'(cap_wstrb), 32'hF);
        check("wr1_both_same_cycle", 32'(vs), 32'd0);

        // 2: read with arready delayed 3 cycles
        cfg_ar_dly = 3; cfg_rdata = 32'h1234_5678; last_rd = 32'h1234_5678;
        sb.push_back({last_rd, 1'b0});
        do_req(1'b0, 32'h1000_0008, 32'h0, 6, 8'h00, "rd2", ac, vs);
        check("rd2_arvalid_cycles", ac, 4);
        check("rd2_araddr", cap_araddr, 32'h1000_0008);
        cfg_ar_dly = 0;

        // 3: wready two cycles after awready
        cfg_w_dly = 2;
        sb.push_back({last_rd, 1'b0});
        do_req(1'b1, 32'h2000_0010, 32'hCAFE_F00D, 5, 8'h00, "wr3", ac, vs);
        check("wr3_aw_drops_first", 32'(vs), 32'd1);
        check("wr3_aw_count", aw_hs_n, 2);
        check("wr3_w_count", w_hs_n, 2);
        check("wr3_b_count", b_hs_n, 2);
        check("wr3_ack_count", ack_n, 3);
        check("wr3_wdata", cap_wdata, 32'hCAFE_F00D);
        cfg_w_dly = 0;

        // 4: SLVERR read, then OKAY write, then DECERR write
        cfg_rresp = 2'b10; cfg_rdata = 32'hBAD0_BAD0; last_rd = 32'hBAD0_BAD0;
        sb.push_back({last_rd, 1'b1});
        do_req(1'b0, 32'h1000_000C, 32'h0, 3, 8'h00, "rd4_err", ac, vs);
        cfg_rresp = 2'b00;
        sb.push_back({last_rd, 1'b0});
        do_req(1'b1, 32'h1000_0010, 32'h0000_0001, 3, 8'h00, "wr4_ok", ac, vs);
        cfg_bresp = 2'b11;
        sb.push_back({last_rd, 1'b1});
        do_req(1'b1, 32'h1000_0014, 32'h0000_0002, 3, 8'h00, "wr4_decerr", ac, vs);
        cfg_bresp = 2'b00;

        // 5: extra starts in RD_RESP and DONE cycles are ignored
        ar0 = ar_hs_n;
        cfg_rdata = 32'h0F0F_1234; last_rd = 32'h0F0F_1234;
        sb.push_back({last_rd, 1'b0});
        do_req(1'b0, 32'h3000_0000, 32'h0, 3, 8'b0000_1100, "rd5", ac, vs);
        repeat (3) @(negedge clk);
        check("rd5_no_new_ar", 32'(m_axi_arvalid), 32'd0);
        check("rd5_still_idle", 32'(busy), 32'd0);
        check("rd5_single_ar", ar_hs_n, ar0 + 1);

        // 6: reset during WR_RESP
        cfg_b_stall = 1'b1;
        burst_type_private = 1'b1;
        address_write_private = 32'h4000_0000;
        data_write_private = 32'h5555_AAAA;
        start_burst_private = 1'b1;
        @(negedge clk);
        start_burst_private = 1'b0;
        repeat (3) @(negedge clk);
        check("rst6_in_wr_resp", 32'({m_axi_bready, busy}), 32'h3);
        b0 = b_hs_n;
        rst = 1'b1;
        #1;
        check("rst6_async_clear", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                       m_axi_rready, mem_ack_private, busy}), 32'd0);
        last_rd = '0;
        check("rst6_rdata_clear", data_read_input_private, last_rd);
        @(negedge clk);
        cfg_b_stall = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        sb.push_back({last_rd, 1'b0});
        do_req(1'b1, 32'h4000_0004, 32'h0123_4567, 3, 8'h00, "wr6_after_rst", ac, vs);
        check("wr6_single_b", b_hs_n, b0 + 1);
        check("wr6_wdata", cap_wdata, 32'h0123_4567);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
